// File: rtl/gpu_pkg.sv
// Shared constants for the GPU core: scheduler and fetcher state codes and the
// program-memory widths used by the fetch stage.
package gpu_pkg;

  localparam int ADDR_BITS  = 8;
  localparam int DATA_BITS  = 16;
  localparam int COUNT_BITS = 16;

  localparam logic [2:0] IDLE    = 3'b000;
  localparam logic [2:0] FETCH   = 3'b001;
  localparam logic [2:0] DECODE  = 3'b010;
  localparam logic [2:0] REQUEST = 3'b011;
  localparam logic [2:0] WAIT    = 3'b100;
  localparam logic [2:0] EXECUTE = 3'b101;
  localparam logic [2:0] UPDATE  = 3'b110;
  localparam logic [2:0] DONE    = 3'b111;

  typedef enum logic [2:0] {
    FETCH_IDLE     = 3'b000,
    FETCH_FETCHING = 3'b001,
    FETCH_FETCHED  = 3'b010
  } fetcher_state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction storage, one instruction per line: combinational
// lookup, synchronous fill, synchronous flush of the valid bits.
module icache_array #(
  parameter int CACHE_LINES = 8,
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_flush,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data
);

  localparam int INDEX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  if (CACHE_LINES < 2 || CACHE_LINES > 64 || (CACHE_LINES & (CACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("icache_array: CACHE_LINES must be a power of 2 in 2..64");
  end

  logic [CACHE_LINES-1:0] r_valid;
  logic [TAG_BITS-1:0]    r_tag  [CACHE_LINES];
  logic [DATA_BITS-1:0]   r_data [CACHE_LINES];

  logic [INDEX_BITS-1:0] w_rd_index;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [INDEX_BITS-1:0] w_wr_index;
  logic [TAG_BITS-1:0]   w_wr_tag;

  assign w_rd_index = i_rd_addr[INDEX_BITS-1:0];
  assign w_rd_tag   = i_rd_addr[ADDR_BITS-1:INDEX_BITS];
  assign w_wr_index = i_wr_addr[INDEX_BITS-1:0];
  assign w_wr_tag   = i_wr_addr[ADDR_BITS-1:INDEX_BITS];

  assign hit     = r_valid[w_rd_index] && (r_tag[w_rd_index] == w_rd_tag);
  assign rd_data = r_data[w_rd_index];

  // A flush on the fill edge wins: the line is written but left invalid.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[w_wr_index]  <= w_wr_tag;
      r_data[w_wr_index] <= i_wr_data;
    end
  end

endmodule

// File: rtl/icache_fetcher.sv
// Instruction fetch stage: one-cycle hits from a small direct-mapped cache,
// misses issue a single program-memory read and fill the line.
module icache_fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = ADDR_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = DATA_BITS,
  parameter int CACHE_LINES           = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNT_BITS-1:0]            hit_count,
  output logic [COUNT_BITS-1:0]            miss_count
);

  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
    return (v == {COUNT_BITS{1'b1}}) ? v : v + 1'b1;
  endfunction

  fetcher_state_e r_state;
  fetcher_state_e w_next_state;

  logic                             r_mem_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instruction;
  logic [COUNT_BITS-1:0]            r_hit_count;
  logic [COUNT_BITS-1:0]            r_miss_count;

  logic                             w_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] w_rd_data;
  logic                             w_hit_evt;
  logic                             w_miss_evt;
  logic                             w_fill;

  icache_array #(
    .CACHE_LINES (CACHE_LINES),
    .ADDR_BITS   (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS   (PROGRAM_MEM_DATA_BITS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (flush),
    .i_rd_addr (current_pc),
    .hit       (w_hit),
    .rd_data   (w_rd_data),
    .i_wr_en   (w_fill),
    .i_wr_addr (r_mem_addr),
    .i_wr_data (mem_read_data)
  );

  always_comb begin
    w_next_state = r_state;
    w_hit_evt    = 1'b0;
    w_miss_evt   = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      FETCH_IDLE: begin
        if (core_state == FETCH) begin
          if (w_hit) begin
            w_hit_evt    = 1'b1;
            w_next_state = FETCH_FETCHED;
          end else begin
            w_miss_evt   = 1'b1;
            w_next_state = FETCH_FETCHING;
          end
        end
      end
      FETCH_FETCHING: begin
        if (mem_read_ready) begin
          w_fill       = 1'b1;
          w_next_state = FETCH_FETCHED;
        end
      end
      FETCH_FETCHED: begin
        if (core_state == DECODE) begin
          w_next_state = FETCH_IDLE;
        end
      end
      default: w_next_state = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FETCH_IDLE;
      r_mem_valid   <= 1'b0;
      r_mem_addr    <= '0;
      r_instruction <= '0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_hit_evt) begin
        r_instruction <= w_rd_data;
        r_hit_count   <= sat_inc(r_hit_count);
      end
      if (w_miss_evt) begin
        r_mem_valid  <= 1'b1;
        r_mem_addr   <= current_pc;
        r_miss_count <= sat_inc(r_miss_count);
      end
      // The request address stays put after the fill; it is the fill's write address.
      if (w_fill) begin
        r_instruction <= mem_read_data;
        r_mem_valid   <= 1'b0;
      end
    end
  end

  assign fetcher_state    = r_state;
  assign mem_read_valid   = r_mem_valid;
  assign mem_read_address = r_mem_addr;
  assign instruction      = r_instruction;
  assign hit_count        = r_hit_count;
  assign miss_count       = r_miss_count;

endmodule
